// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 responder backing a word-addressed scratchpad with
// independent single-outstanding read and write burst engines.
module axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0F00_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready_o,
  input  logic        awvalid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awid_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  output logic        wready_o,
  input  logic        wvalid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        bready_i,
  output logic        bvalid_o,
  output logic [1:0]  bresp_o,
  output logic [3:0]  bid_o,
  output logic        arready_o,
  input  logic        arvalid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        rready_i,
  output logic        rvalid_o,
  output logic [1:0]  rresp_o,
  output logic [31:0] rdata_o,
  output logic        rlast_o,
  output logic [3:0]  rid_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [31:0] mem_q [DEPTH_WORDS];
  function automatic logic in_rng(input logic [31:0] a);
    return (a - ADDR_BASE) < 32'(4 * DEPTH_WORDS);
  endfunction
  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 2);
  endfunction
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] s, input logic fixed);
    return fixed ? a : a + (32'd1 << s);
  endfunction
  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]  r_size_q, r_size_d;
  logic        r_fixed_q, r_fixed_d, r_slv_q, r_slv_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [LW-1:0] r_wait_q, r_wait_d;
  logic        r_dec;
  always_ff @(posedge clock) begin
    r_state_q <= reset ? R_IDLE : r_state_d;
    r_addr_q  <= r_addr_d;
    r_len_q   <= r_len_d;
    r_beat_q  <= r_beat_d;
    r_size_q  <= r_size_d;
    r_fixed_q <= r_fixed_d;
    r_slv_q   <= r_slv_d;
    r_id_q    <= r_id_d;
    r_wait_q  <= r_wait_d;
  end
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_size_d  = r_size_q;
    r_fixed_d = r_fixed_q;
    r_slv_d   = r_slv_q;
    r_id_d    = r_id_q;
    r_wait_d  = r_wait_q;
    case (r_state_q)
      R_IDLE: if (arvalid_i) begin
        r_addr_d  = araddr_i;
        r_len_d   = arlen_i;
        r_size_d  = arsize_i;
        r_fixed_d = arburst_i == 2'd0;
        r_slv_d   = (arburst_i > 2'd1) || (arsize_i > 3'd2);
        r_id_d    = arid_i;
        r_beat_d  = '0;
        r_wait_d  = '0;
        r_state_d = (LATENCY > 0) ? R_WAIT : R_DATA;
      end
      R_WAIT: begin
        r_wait_d  = r_wait_q + 1'b1;
        r_state_d = (r_wait_q == LW'(LATENCY - 1)) ? R_DATA : R_WAIT;
      end
      R_DATA: if (rready_i) begin
        r_state_d = (r_beat_q == r_len_q) ? R_IDLE : R_DATA;
        r_beat_d  = r_beat_q + 8'd1;
        r_addr_d  = nxt(r_addr_q, r_size_q, r_fixed_q);
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  assign r_dec     = ~in_rng(r_addr_q);
  assign arready_o = ~reset & (r_state_q == R_IDLE);
  assign rvalid_o  = ~reset & (r_state_q == R_DATA);
  assign rresp_o   = ~rvalid_o ? 2'd0 : r_slv_q ? 2'd2 : r_dec ? 2'd3 : 2'd0;
  assign rdata_o   = (rvalid_o & ~r_slv_q & ~r_dec) ? mem_q[widx(r_addr_q)] : 32'd0;
  assign rlast_o   = rvalid_o & (r_beat_q == r_len_q);
  assign rid_o     = rvalid_o ? r_id_q : 4'd0;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]  w_size_q, w_size_d;
  logic        w_fixed_q, w_fixed_d, w_slv_q, w_slv_d, w_dec_q, w_dec_d, w_over_q, w_over_d;
  logic [3:0]  w_id_q, w_id_d;
  logic        w_ok, we;
  always_ff @(posedge clock) begin
    w_state_q <= reset ? W_IDLE : w_state_d;
    w_addr_q  <= w_addr_d;
    w_len_q   <= w_len_d;
    w_beat_q  <= w_beat_d;
    w_size_q  <= w_size_d;
    w_fixed_q <= w_fixed_d;
    w_slv_q   <= w_slv_d;
    w_dec_q   <= w_dec_d;
    w_over_q  <= w_over_d;
    w_id_q    <= w_id_d;
  end
  // w_slv_q only holds a setup error while in W_DATA; mismatch SLVERR is added on wlast.
  assign w_ok = ~w_over_q & ~w_slv_q;
  assign we   = wready_o & wvalid_i & w_ok & in_rng(w_addr_q);
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_size_d  = w_size_q;
    w_fixed_d = w_fixed_q;
    w_slv_d   = w_slv_q;
    w_dec_d   = w_dec_q;
    w_over_d  = w_over_q;
    w_id_d    = w_id_q;
    case (w_state_q)
      W_IDLE: if (awvalid_i) begin
        w_addr_d  = awaddr_i;
        w_len_d   = awlen_i;
        w_size_d  = awsize_i;
        w_fixed_d = awburst_i == 2'd0;
        w_slv_d   = (awburst_i > 2'd1) || (awsize_i > 3'd2);
        w_id_d    = awid_i;
        w_beat_d  = '0;
        w_dec_d   = 1'b0;
        w_over_d  = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid_i) begin
        w_dec_d = w_dec_q | (w_ok & ~in_rng(w_addr_q));
        if (wlast_i) begin
          w_state_d = W_RESP;
          w_slv_d   = w_slv_q | w_over_q | (w_beat_q != w_len_q);
        end else begin
          w_over_d = w_over_q | (w_beat_q == w_len_q);
          w_beat_d = w_beat_q + 8'd1;
          w_addr_d = nxt(w_addr_q, w_size_q, w_fixed_q);
        end
      end
      W_RESP: if (bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < 4; i++)
        if (wstrb_i[i]) mem_q[widx(w_addr_q)][8*i +: 8] <= wdata_i[8*i +: 8];
  assign awready_o = ~reset & (w_state_q == W_IDLE);
  assign wready_o  = ~reset & (w_state_q == W_DATA);
  assign bvalid_o  = ~reset & (w_state_q == W_RESP);
  assign bresp_o   = ~bvalid_o ? 2'd0 : w_slv_q ? 2'd2 : w_dec_q ? 2'd3 : 2'd0;
  assign bid_o     = bvalid_o ? w_id_q : 4'd0;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: random and directed AXI4 traffic checked against an
// array-based reference memory and closed-form beat/response rules.
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h0F00_0000;
  localparam int DEPTH = 1024;
  localparam int LAT = 1;
  logic        clock = 0, reset = 1;
  logic        awready_o, awvalid_i = 0, wready_o, wvalid_i = 0, wlast_i = 0;
  logic [31:0] awaddr_i = 0, wdata_i = 0, araddr_i = 0, rdata_o;
  logic [3:0]  awid_i = 0, wstrb_i = 0, bid_o, arid_i = 0, rid_o;
  logic [7:0]  awlen_i = 0, arlen_i = 0;
  logic [2:0]  awsize_i = 0, arsize_i = 0;
  logic [1:0]  awburst_i = 0, arburst_i = 0, bresp_o, rresp_o;
  logic        bready_i = 0, bvalid_o, arready_o, arvalid_i = 0, rready_i = 0, rvalid_o, rlast_o;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  axi4_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .awready_o(awready_o), .awvalid_i(awvalid_i), .awaddr_i(awaddr_i), .awid_i(awid_i),
    .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
    .wready_o(wready_o), .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .bready_i(bready_i), .bvalid_o(bvalid_o), .bresp_o(bresp_o), .bid_o(bid_o),
    .arready_o(arready_o), .arvalid_i(arvalid_i), .araddr_i(araddr_i), .arid_i(arid_i),
    .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
    .rready_i(rready_i), .rvalid_o(rvalid_o), .rresp_o(rresp_o), .rdata_o(rdata_o),
    .rlast_o(rlast_o), .rid_o(rid_o));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] s, input logic [1:0] bu, input int b);
    return (bu == 2'd0) ? a : a + 32'(b) * (32'd1 << s);
  endfunction
  function automatic logic inr(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction
  function automatic logic setup_err(input logic [2:0] s, input logic [1:0] bu);
    return (bu > 2'd1) || (s > 3'd2);
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                          input logic [1:0] bu, input int nb, output logic [1:0] resp);
    logic dec = 0;
    logic [31:0] ad;
    if (!setup_err(s, bu))
      for (int b = 0; b < nb && b <= int'(len); b++) begin
        ad = baddr(a, s, bu, b);
        if (!inr(ad)) dec = 1;
        else for (int i = 0; i < 4; i++)
          if (ws_q[b][i]) mdl[(ad - BASE) >> 2][8*i +: 8] = wd_q[b][8*i +: 8];
      end
    resp = (setup_err(s, bu) || nb != int'(len) + 1) ? 2'd2 : dec ? 2'd3 : 2'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                    input logic [1:0] bu, input logic [3:0] id, input int nb, input bit rnd);
    logic [1:0] er;
    int n;
    model_wr(a, len, s, bu, nb, er);
    @(negedge clock);
    awaddr_i = a; awlen_i = len; awsize_i = s; awburst_i = bu; awid_i = id; awvalid_i = 1;
    n = 0;
    while (!awready_o && n < 50) begin @(negedge clock); n++; end
    check("awready", awready_o, 1);
    @(negedge clock);
    awvalid_i = 0;
    for (int b = 0; b < nb; b++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin wvalid_i = 0; @(negedge clock); end
      wvalid_i = 1; wdata_i = wd_q[b]; wstrb_i = ws_q[b]; wlast_i = (b == nb - 1);
      n = 0;
      while (!wready_o && n < 50) begin @(negedge clock); n++; end
      @(negedge clock);
    end
    wvalid_i = 0; wlast_i = 0;
    n = 0;
    while (!bvalid_o && n < 50) begin @(negedge clock); n++; end
    check("bvalid", bvalid_o, 1);
    repeat ($urandom_range(0, 2)) begin
      check("bresp_hold", bresp_o, er);
      @(negedge clock);
    end
    check("bresp", bresp_o, er);
    check("bid", bid_o, id);
    bready_i = 1;
    @(negedge clock);
    bready_i = 0;
    check("b_done", {bvalid_o, awready_o}, 2'b01);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                    input logic [1:0] bu, input logic [3:0] id, input int stall_beat,
                    input int abort_after, input bit rnd);
    int n, lat, b, stalled, guard;
    logic [31:0] ad;
    logic ok;
    @(negedge clock);
    araddr_i = a; arlen_i = len; arsize_i = s; arburst_i = bu; arid_i = id; arvalid_i = 1;
    rready_i = 1;
    n = 0;
    while (!arready_o && n < 50) begin @(negedge clock); n++; end
    check("arready", arready_o, 1);
    @(negedge clock);
    arvalid_i = 0;
    lat = 1;
    while (!rvalid_o && lat < 50) begin @(negedge clock); lat++; end
    check("r_latency", lat, LAT + 1);
    b = 0; stalled = 0; guard = 0;
    while (b <= int'(len) && guard < 3000) begin
      guard++;
      ad = baddr(a, s, bu, b);
      ok = inr(ad) && !setup_err(s, bu);
      check("rvalid", rvalid_o, 1);
      check("rdata", rdata_o, ok ? mdl[(ad - BASE) >> 2] : 32'd0);
      check("rresp", rresp_o, setup_err(s, bu) ? 2'd2 : inr(ad) ? 2'd0 : 2'd3);
      check("rlast", rlast_o, b == int'(len));
      check("rid", rid_o, id);
      if (b == stall_beat && stalled < 5) begin rready_i = 0; stalled++; end
      else rready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      if (rready_i) begin
        b++;
        if (abort_after >= 0 && b == abort_after) begin rready_i = 0; return; end
      end
    end
    rready_i = 0;
    check("r_done", {rvalid_o, arready_o}, 2'b01);
  endtask

  task automatic fill1(input logic [31:0] d, input logic [3:0] st);
    wd_q = {}; ws_q = {};
    wd_q.push_back(d); ws_q.push_back(st);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0] len;
    logic [2:0] s;
    logic [1:0] bu;
    int nb, r;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
    repeat (3) begin
      @(negedge clock);
      check("rst_outputs", {awready_o, wready_o, bvalid_o, bresp_o, bid_o, arready_o,
                            rvalid_o, rresp_o, rdata_o, rlast_o, rid_o}, 0);
    end
    reset = 0;
    @(negedge clock);
    check("idle_ready", {awready_o, arready_o, wready_o}, 3'b110);
    wvalid_i = 1; wlast_i = 1;
    @(negedge clock);
    check("w_before_aw", {wready_o, bvalid_o}, 2'b00);
    wvalid_i = 0; wlast_i = 0;
    // Fill the whole array with 256-beat bursts so every word has a known value.
    for (int k = 0; k < 4; k++) begin
      wd_q = {}; ws_q = {};
      for (int i = 0; i < 256; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
      wr(BASE + 32'(k * 1024), 8'd255, 3'd2, 2'd1, 4'(k), 256, 0);
    end
    fill1(32'hDEADBEEF, 4'hF);
    wr(BASE, 0, 2, 1, 1, 1, 0);
    rd(BASE, 0, 2, 1, 3, -1, -1, 0);
    wd_q = {32'd1, 32'd2, 32'd3, 32'd4}; ws_q = {4'hF, 4'hF, 4'hF, 4'hF};
    wr(BASE + 8, 3, 2, 1, 5, 4, 0);
    rd(BASE + 8, 3, 2, 1, 6, -1, -1, 0);
    fill1(32'h11223344, 4'hF);
    wr(BASE + 32'h40, 0, 2, 1, 2, 1, 0);
    fill1(32'hAABBCCDD, 4'b0101);
    wr(BASE + 32'h40, 0, 2, 1, 2, 1, 0);
    rd(BASE + 32'h40, 0, 2, 1, 2, -1, -1, 0);
    rd(BASE + 32'(4 * (DEPTH - 1)), 1, 2, 1, 4, -1, -1, 0);
    wd_q = {32'h5555AAAA, 32'h1234}; ws_q = {4'hF, 4'hF};
    wr(BASE + 32'h80, 1, 2, 2'd2, 9, 2, 0);
    rd(BASE + 32'h80, 1, 2, 1, 9, -1, -1, 0);
    rd(BASE + 32'h100, 3, 2, 1, 8, 1, -1, 0);
    wd_q = {32'hA1, 32'hA2, 32'hA3, 32'hA4}; ws_q = {4'hF, 4'hF, 4'hF, 4'hF};
    wr(BASE + 32'h200, 3, 2, 1, 10, 2, 0);
    rd(BASE + 32'h200, 3, 2, 1, 10, -1, -1, 0);
    wr(BASE + 32'h300, 1, 2, 1, 11, 4, 0);
    rd(BASE + 32'h300, 3, 2, 1, 11, -1, -1, 0);
    rd(BASE, 3, 2, 1, 7, -1, 1, 0);
    reset = 1;
    @(negedge clock);
    check("rst_mid_read", {rvalid_o, arready_o, rdata_o, rlast_o}, 0);
    reset = 0;
    @(negedge clock);
    check("after_rst", {arready_o, rvalid_o}, 2'b10);
    rd(BASE, 3, 2, 1, 7, -1, -1, 0);
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      a = (r < 7) ? BASE + ($urandom_range(0, 4095) & ~32'd3)
        : (r < 9) ? BASE + 32'(4 * DEPTH) - 32'($urandom_range(1, 12)) : BASE - 32'd8;
      s = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      bu = (r < 7) ? 2'd1 : (r < 9) ? 2'd0 : 2'($urandom_range(2, 3));
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 9);
        nb = (r < 8) ? int'(len) + 1 : (r == 8 && len > 0) ? int'(len) : int'(len) + 2;
        wd_q = {}; ws_q = {};
        for (int i = 0; i < nb; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'($urandom)); end
        wr(a, len, s, bu, 4'($urandom), nb, 1);
      end else
        rd(a, len, s, bu, 4'($urandom), -1, -1, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
